// File: rtl/regfile_bypass_pkg.sv
// Shared constants and types for the architectural register file with
// same-cycle write bypass and multi-cycle writer scoreboard.
package regfile_bypass_pkg;

    localparam int WIDTH      = 32;
    localparam int NUM_REGS   = 32;
    localparam int IDX_W      = 5;
    localparam int STATUS_REG = 30;
    localparam int RA_REG     = 31;

    typedef logic [IDX_W-1:0]    reg_idx_t;
    typedef logic [WIDTH-1:0]    word_t;
    typedef logic [NUM_REGS-1:0] reg_vec_t;

    localparam reg_idx_t ZERO_IDX   = 5'd0;
    localparam reg_idx_t STATUS_IDX = 5'd30;
    localparam reg_idx_t RA_IDX     = 5'd31;

    // One-hot select of an index; r0 never appears in the result.
    function automatic reg_vec_t idx_onehot(input reg_idx_t idx);
        reg_vec_t vec;
        vec = '0;
        vec[idx] = 1'b1;
        vec[0] = 1'b0;
        return vec;
    endfunction

    // True when an active write on the given port targets the read index.
    function automatic logic write_hits(input logic en, input reg_idx_t wr_idx,
                                        input reg_idx_t rd_idx);
        return en && (wr_idx == rd_idx) && (rd_idx != ZERO_IDX);
    endfunction

endpackage

// File: rtl/regfile_bypass_scoreboard.sv
// Busy tracking for in-flight multi-cycle writers and the decode stall that
// results from reading a register that has not yet been written back.
module regfile_bypass_scoreboard
    import regfile_bypass_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     issue_valid,
    input  reg_idx_t issue_reg,
    input  logic     clear_valid,
    input  reg_idx_t clear_reg,
    input  reg_idx_t read_a,
    input  reg_idx_t read_b,
    output logic     stall
);

    reg_vec_t busy_r;
    reg_vec_t set_vec_s;
    reg_vec_t clr_vec_s;
    reg_vec_t busy_next_s;
    logic     stall_a_s;
    logic     stall_b_s;

    // Set wins over clear: the issuing writer is younger than the one retiring.
    always_comb begin
        set_vec_s   = '0;
        clr_vec_s   = '0;
        if (issue_valid) begin
            set_vec_s = idx_onehot(issue_reg);
        end else begin
            set_vec_s = '0;
        end
        if (clear_valid) begin
            clr_vec_s = idx_onehot(clear_reg);
        end else begin
            clr_vec_s = '0;
        end
        busy_next_s = (busy_r & ~clr_vec_s) | set_vec_s;
    end

    // Busy vector register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // A retiring write this cycle is bypassed, so it does not stall.
    always_comb begin
        stall_a_s = 1'b0;
        stall_b_s = 1'b0;
        if (read_a != ZERO_IDX) begin
            stall_a_s = busy_r[read_a] && !write_hits(clear_valid, clear_reg, read_a);
        end else begin
            stall_a_s = 1'b0;
        end
        if (read_b != ZERO_IDX) begin
            stall_b_s = busy_r[read_b] && !write_hits(clear_valid, clear_reg, read_b);
        end else begin
            stall_b_s = 1'b0;
        end
        stall = stall_a_s || stall_b_s;
    end

endmodule

// File: rtl/regfile_bypass.sv
// Architectural register file: r0 hardwired to zero, normal and rstatus
// write ports, zero-latency reads with same-cycle write forwarding.
module regfile_bypass
    import regfile_bypass_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_writeEnable,
    input  logic [IDX_W-1:0] ctrl_writeReg,
    input  logic [WIDTH-1:0] data_writeReg,
    input  logic             ctrl_writeStatus,
    input  logic [WIDTH-1:0] data_writeStatusReg,
    input  logic [IDX_W-1:0] ctrl_readRegA,
    input  logic [IDX_W-1:0] ctrl_readRegB,
    output logic [WIDTH-1:0] data_readRegA,
    output logic [WIDTH-1:0] data_readRegB,
    input  logic             issue_valid,
    input  logic [IDX_W-1:0] issue_reg,
    output logic             stall
);

    word_t regs_r [NUM_REGS];
    logic  norm_we_s;

    assign norm_we_s = ctrl_writeEnable && (ctrl_writeReg != ZERO_IDX);

    // Storage update; the status port overrides the normal port on r30.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            regs_r[0] <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (ctrl_writeStatus && (i == STATUS_REG)) begin
                    regs_r[i] <= data_writeStatusReg;
                end else if (norm_we_s && (ctrl_writeReg == reg_idx_t'(i))) begin
                    regs_r[i] <= data_writeReg;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Operand A read with bypass in the same priority order as storage.
    always_comb begin
        data_readRegA = '0;
        if (ctrl_readRegA == ZERO_IDX) begin
            data_readRegA = '0;
        end else if (ctrl_writeStatus && (ctrl_readRegA == STATUS_IDX)) begin
            data_readRegA = data_writeStatusReg;
        end else if (write_hits(ctrl_writeEnable, ctrl_writeReg, ctrl_readRegA)) begin
            data_readRegA = data_writeReg;
        end else begin
            data_readRegA = regs_r[ctrl_readRegA];
        end
    end

    // Operand B read, independent of A.
    always_comb begin
        data_readRegB = '0;
        if (ctrl_readRegB == ZERO_IDX) begin
            data_readRegB = '0;
        end else if (ctrl_writeStatus && (ctrl_readRegB == STATUS_IDX)) begin
            data_readRegB = data_writeStatusReg;
        end else if (write_hits(ctrl_writeEnable, ctrl_writeReg, ctrl_readRegB)) begin
            data_readRegB = data_writeReg;
        end else begin
            data_readRegB = regs_r[ctrl_readRegB];
        end
    end

    regfile_bypass_scoreboard u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .clear_valid (ctrl_writeEnable),
        .clear_reg   (ctrl_writeReg),
        .read_a      (ctrl_readRegA),
        .read_b      (ctrl_readRegB),
        .stall       (stall)
    );

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed self-checking bench for regfile_bypass: reset, r0, bypass,
// status priority and scoreboard stall behaviour.
module tb_regfile_bypass;

    logic        clock;
    logic        reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        ctrl_writeStatus;
    logic [31:0] data_writeStatusReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic        stall;

    int total;
    int bad;

    regfile_bypass dut (
        .clock               (clock),
        .reset               (reset),
        .ctrl_writeEnable    (ctrl_writeEnable),
        .ctrl_writeReg       (ctrl_writeReg),
        .data_writeReg       (data_writeReg),
        .ctrl_writeStatus    (ctrl_writeStatus),
        .data_writeStatusReg (data_writeStatusReg),
        .ctrl_readRegA       (ctrl_readRegA),
        .ctrl_readRegB       (ctrl_readRegB),
        .data_readRegA       (data_readRegA),
        .data_readRegB       (data_readRegB),
        .issue_valid         (issue_valid),
        .issue_reg           (issue_reg),
        .stall               (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and return just after the following falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_writes();
        ctrl_writeEnable    = 1'b0;
        ctrl_writeReg       = 5'd0;
        data_writeReg       = 32'd0;
        ctrl_writeStatus    = 1'b0;
        data_writeStatusReg = 32'd0;
        issue_valid         = 1'b0;
        issue_reg           = 5'd0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle_writes();
        ctrl_readRegA = 5'd5;
        ctrl_readRegB = 5'd6;
        #3;
        check("reset_a", data_readRegA, 32'd0);
        check("reset_b", data_readRegB, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // 1: write r5 and issue r6, then reset asynchronously mid-cycle
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'hDEADBEEF;
        issue_valid = 1'b1; issue_reg = 5'd6;
        step();
        idle_writes();
        #1;
        check("r5_written", data_readRegA, 32'hDEADBEEF);
        check("r6_busy_stall", {31'd0, stall}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async_reset_r5", data_readRegA, 32'd0);
        check("async_reset_stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // 2: writes to r0 are dropped
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'hFFFFFFFF;
        ctrl_readRegA = 5'd0;
        #1;
        check("r0_write_cycle", data_readRegA, 32'd0);
        step();
        idle_writes();
        #1;
        check("r0_after", data_readRegA, 32'd0);

        // 3: same-cycle bypass to both ports
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'h12345678;
        ctrl_readRegA = 5'd7; ctrl_readRegB = 5'd7;
        #1;
        check("bypass_a", data_readRegA, 32'h12345678);
        check("bypass_b", data_readRegB, 32'h12345678);
        step();
        idle_writes();
        #1;
        check("r7_stored", data_readRegB, 32'h12345678);

        // 4: status port beats normal port on r30
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd30; data_writeReg = 32'h5;
        ctrl_writeStatus = 1'b1; data_writeStatusReg = 32'h1;
        ctrl_readRegA = 5'd30; ctrl_readRegB = 5'd7;
        #1;
        check("status_bypass", data_readRegA, 32'h1);
        check("b_unaffected", data_readRegB, 32'h12345678);
        step();
        idle_writes();
        #1;
        check("status_stored", data_readRegA, 32'h1);

        // 5: scoreboard stall on r9 until writeback
        issue_valid = 1'b1; issue_reg = 5'd9;
        ctrl_readRegA = 5'd0; ctrl_readRegB = 5'd0;
        #1;
        check("issue_cycle_stall", {31'd0, stall}, 32'd0);
        step();
        idle_writes();
        ctrl_readRegA = 5'd9;
        #1;
        check("r9_stall", {31'd0, stall}, 32'd1);
        step();
        #1;
        check("r9_still_stall", {31'd0, stall}, 32'd1);
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'hAA;
        #1;
        check("r9_wb_stall", {31'd0, stall}, 32'd0);
        check("r9_wb_data", data_readRegA, 32'hAA);
        step();
        idle_writes();
        #1;
        check("r9_after_stall", {31'd0, stall}, 32'd0);
        check("r9_after_data", data_readRegA, 32'hAA);

        // 6: set and clear of r4 together keeps it busy; seen on port B
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd4; data_writeReg = 32'h44;
        issue_valid = 1'b1; issue_reg = 5'd4;
        ctrl_readRegA = 5'd0; ctrl_readRegB = 5'd0;
        step();
        idle_writes();
        ctrl_readRegB = 5'd4;
        #1;
        check("r4_setwins_stall", {31'd0, stall}, 32'd1);
        check("r4_stored", data_readRegB, 32'h44);
        ctrl_readRegB = 5'd0;
        #1;
        check("r0_no_stall", {31'd0, stall}, 32'd0);
        ctrl_readRegB = 5'd4;
        ctrl_writeStatus = 1'b1; data_writeStatusReg = 32'h77;
        step();
        idle_writes();
        #1;
        check("status_no_clear", {31'd0, stall}, 32'd1);
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd4; data_writeReg = 32'h88;
        step();
        idle_writes();
        #1;
        check("r4_cleared", {31'd0, stall}, 32'd0);
        check("r4_new", data_readRegB, 32'h88);

        // r31 round trip and the r30 value left by the status-only write
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd31; data_writeReg = 32'hCAFEF00D;
        step();
        idle_writes();
        ctrl_readRegA = 5'd31; ctrl_readRegB = 5'd30;
        #1;
        check("r31_stored", data_readRegA, 32'hCAFEF00D);
        check("r30_status_only", data_readRegB, 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
